// File: rtl/gp_pkg.sv
// Shared definitions for the general-purpose register file and its write-port users.
package gp_pkg;

  localparam int unsigned GPR_AW  = 4;
  localparam int unsigned GPR_DW  = 32;
  localparam int unsigned GPR_NUM = 1 << GPR_AW;

  localparam logic [1:0] SCOPE_NONE = 2'b00;
  localparam logic [1:0] SCOPE_LO   = 2'b01;
  localparam logic [1:0] SCOPE_HI   = 2'b10;
  localparam logic [1:0] SCOPE_FULL = 2'b11;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: round-robin on contention, or fixed A-priority when FIXED_PRI=1.
module rr_arb2
  import gp_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_e last_grant;

  // Grants are suppressed during reset so no handshake can complete.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (req_a && req_b) begin
        if (FIXED_PRI || (last_grant == REQ_B)) gnt_a = 1'b1;
        else                                    gnt_b = 1'b1;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_grant <= REQ_B;
    else if (gnt_a) last_grant <= REQ_A;
    else if (gnt_b) last_grant <= REQ_B;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single gp_regs write port between the execute (A) and load-return (B) paths.
module wb_port_arbiter
  import gp_pkg::*;
#(
  parameter int unsigned DW        = GPR_DW,
  parameter int unsigned AW        = GPR_AW,
  parameter int unsigned FIXED_PRI = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid_i,
  input  logic [AW-1:0]        a_idx_i,
  input  logic [DW-1:0]        a_data_i,
  input  logic [1:0]           a_scope_i,
  output logic                 a_ready_o,
  input  logic                 b_valid_i,
  input  logic [AW-1:0]        b_idx_i,
  input  logic [DW-1:0]        b_data_i,
  input  logic [1:0]           b_scope_i,
  output logic                 b_ready_o,
  output logic [AW-1:0]        reg_w_idx_o,
  output logic [DW-1:0]        wdata_o,
  output logic                 wen_o,
  output logic [1:0]           wr_scope_o,
  output logic [(1<<AW)-1:0]   busy_o,
  output logic [CNT_W-1:0]     conflict_cnt_o,
  input  logic                 clr_cnt_i
);

  localparam int unsigned NREG = 1 << AW;

  logic          xfer;
  logic [AW-1:0] sel_idx;
  logic [DW-1:0] sel_data;
  logic [1:0]    sel_scope;

  rr_arb2 #(
    .FIXED_PRI (FIXED_PRI != 0)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (a_valid_i),
    .req_b (b_valid_i),
    .gnt_a (a_ready_o),
    .gnt_b (b_ready_o)
  );

  always_comb begin
    xfer      = a_ready_o | b_ready_o;
    sel_idx   = b_idx_i;
    sel_data  = b_data_i;
    sel_scope = b_scope_i;
    if (a_ready_o) begin
      sel_idx   = a_idx_i;
      sel_data  = a_data_i;
      sel_scope = a_scope_i;
    end
  end

  // A scope-none transfer is consumed but leaves the captured fields untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_o       <= 1'b0;
      reg_w_idx_o <= '0;
      wdata_o     <= '0;
      wr_scope_o  <= SCOPE_NONE;
    end else if (xfer && (sel_scope != SCOPE_NONE)) begin
      wen_o       <= 1'b1;
      reg_w_idx_o <= sel_idx;
      wdata_o     <= sel_data;
      wr_scope_o  <= sel_scope;
    end else begin
      wen_o       <= 1'b0;
    end
  end

  always_comb begin
    busy_o = '0;
    if (wen_o) busy_o = NREG'(1) << reg_w_idx_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conflict_cnt_o <= '0;
    else if (clr_cnt_i)
      conflict_cnt_o <= '0;
    else if (a_valid_i && b_valid_i && (conflict_cnt_o != '1))
      conflict_cnt_o <= conflict_cnt_o + 1'b1;
  end

endmodule
